resize_line_store: RTL and testbench

Three-line pixel store that feeds the bilinear resize datapath. It accepts the camera pixel stream through a valid/ready write port and serves a random-column read port. Each read returns a horizontally adjacent pixel pair from the current line and the same pair from the line below. It is the responder side of the `rd_en`/`rd_addr`/`rd_finish`/`rd_ready` interface driven by the resize address generator. It sits between the sensor input and the interpolation pipeline.

---
 rtl/resize_pkg.sv | 25 ++
 rtl/resize_line_bank.sv | 58 +++++
 rtl/resize_line_store.sv | 162 ++++++++++++++++
 tb/tb_resize_line_store.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resize_pkg.sv
// Shared types and constants for the resize line store: pixel and pair
// types, the bank index type and the mod-3 ring increment.
package resize_pkg;

    localparam int PIX_W     = 24;
    localparam int MAX_WIDTH = 2048;
    localparam int ADDR_W    = 11;
    localparam int HALF_W    = ADDR_W - 1;
    localparam int NUM_BANKS = 3;

    typedef logic [1:0]       bank_idx_t;
    typedef logic [PIX_W-1:0] pix_t;

    // Left pixel sits in the upper half, matching {pix[a], pix[a+1]}.
    typedef struct packed {
        pix_t left;
        pix_t right;
    } pix_pair_t;

    // Advance a bank pointer around the three-bank ring.
    function automatic bank_idx_t bank_next(input bank_idx_t b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

endpackage

// File: rtl/resize_line_bank.sv
// One line of pixels split across an even-column and an odd-column RAM so
// that any horizontally adjacent pair can be read in a single cycle.
module resize_line_bank
    import resize_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_col,
    input  pix_t              wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output pix_pair_t         rd_pair
);

    localparam int DEPTH = MAX_WIDTH / 2;

    pix_t even_mem [DEPTH];
    pix_t odd_mem  [DEPTH];

    pix_t              even_q;
    pix_t              odd_q;
    logic              swap_q;
    logic [HALF_W-1:0] even_idx;
    logic [HALF_W-1:0] odd_idx;

    // For an odd address the left pixel is in the odd RAM and the right one
    // is the next even word; for the last column this index wraps, but the
    // top level replaces that pixel with the left one anyway.
    assign odd_idx  = rd_addr[ADDR_W-1:1];
    assign even_idx = odd_idx + {{(HALF_W-1){1'b0}}, rd_addr[0]};

    // Column LSB selects the RAM, the remaining bits the word.
    // NOTE: RAM arrays carry no reset so they map onto block memory; line
    // contents survive a reset and are simply overwritten by the next frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_col[0]) begin
                odd_mem[wr_col[ADDR_W-1:1]] <= wr_data;
            end else begin
                even_mem[wr_col[ADDR_W-1:1]] <= wr_data;
            end
        end
    end

    // Registered pair read; the LSB is kept to restore column order.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            even_q <= even_mem[even_idx];
            odd_q  <= odd_mem[odd_idx];
            swap_q <= rd_addr[0];
        end
    end

    assign rd_pair = swap_q ? {odd_q, even_q} : {even_q, odd_q};

endmodule

// File: rtl/resize_line_store.sv
// Three-line ring buffer between the pixel stream and the bilinear resize
// datapath: valid/ready write port, pair read port with edge replication.
module resize_line_store
    import resize_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        img_width,
    input  logic [10:0]        img_height,
    input  logic               valid_i,
    input  logic [PIX_W-1:0]   data_i,
    output logic               wr_ready,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_finish,
    output logic               rd_ready,
    output logic               valid_o,
    output logic [2*PIX_W-1:0] cur_line_data_o,
    output logic [2*PIX_W-1:0] next_line_data_o
);

    bank_idx_t         wr_bank;
    bank_idx_t         cur_bank;
    logic [ADDR_W-1:0] wr_col;
    logic [1:0]        full_cnt;
    logic [10:0]       rd_line;

    logic [ADDR_W-1:0] last_col;
    logic [10:0]       last_line;
    logic              accept;
    logic              line_done;
    logic              line_release;
    logic              bottom;
    logic [ADDR_W-1:0] rd_col;

    logic [NUM_BANKS-1:0] bank_we;
    pix_pair_t            bank_pair [NUM_BANKS];

    // Read pipeline stage 1: bank RAM output registers are loading.
    logic      rd_v1;
    logic      at_edge1;
    logic      bottom1;
    bank_idx_t cur_sel1;
    bank_idx_t nxt_sel1;

    pix_pair_t cur_raw;
    pix_pair_t nxt_raw;
    pix_pair_t cur_pair;
    pix_pair_t nxt_pair;

    assign last_col     = ADDR_W'(img_width - 12'd1);
    assign last_line    = img_height - 11'd1;
    assign accept       = valid_i & wr_ready;
    assign line_done    = accept & (wr_col == last_col);
    assign line_release = rd_finish & (full_cnt != 2'd0);
    assign bottom       = (rd_line == last_line);
    assign rd_col       = (rd_addr > last_col) ? last_col : rd_addr;

    assign wr_ready = ~reset & (full_cnt != 2'd3);
    assign rd_ready = ~reset & ((full_cnt >= 2'd2) | ((full_cnt != 2'd0) & bottom));

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign bank_we[i] = accept & (wr_bank == bank_idx_t'(i));

        resize_line_bank u_bank (
            .clk     (clk),
            .wr_en   (bank_we[i]),
            .wr_col  (wr_col),
            .wr_data (data_i),
            .rd_en   (rd_en),
            .rd_addr (rd_col),
            .rd_pair (bank_pair[i])
        );
    end

    // Ring pointers and the count of completed, unreleased lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank  <= '0;
            cur_bank <= '0;
            wr_col   <= '0;
            full_cnt <= '0;
            rd_line  <= '0;
        end else begin
            if (accept) begin
                wr_col <= line_done ? '0 : wr_col + ADDR_W'(1);
            end
            if (line_done) begin
                wr_bank <= bank_next(wr_bank);
            end
            if (line_release) begin
                cur_bank <= bank_next(cur_bank);
                rd_line  <= bottom ? '0 : rd_line + 11'd1;
            end
            // A completed line and a release in the same cycle cancel out.
            case ({line_done, line_release})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // Capture the bank selection and edge flags alongside the RAM read, so a
    // release in the same cycle does not affect the read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_en;
        end
        if (rd_en) begin
            at_edge1 <= (rd_col == last_col);
            bottom1  <= bottom;
            cur_sel1 <= cur_bank;
            nxt_sel1 <= bank_next(cur_bank);
        end
    end

    // Select the two banks and apply right-edge and bottom-edge replication.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        cur_raw = bank_pair[0];
        nxt_raw = bank_pair[0];
        case (cur_sel1)
            2'd1:    cur_raw = bank_pair[1];
            2'd2:    cur_raw = bank_pair[2];
            default: cur_raw = bank_pair[0];
        endcase
        case (nxt_sel1)
            2'd1:    nxt_raw = bank_pair[1];
            2'd2:    nxt_raw = bank_pair[2];
            default: nxt_raw = bank_pair[0];
        endcase
        cur_pair = cur_raw;
        nxt_pair = nxt_raw;
        if (at_edge1) begin
            cur_pair.right = cur_raw.left;
            nxt_pair.right = nxt_raw.left;
        end
        if (bottom1) begin
            nxt_pair = cur_pair;
        end
    end

    // Output register; data holds its last value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o          <= 1'b0;
            cur_line_data_o  <= '0;
            next_line_data_o <= '0;
        end else begin
            valid_o <= rd_v1;
            if (rd_v1) begin
                cur_line_data_o  <= cur_pair;
                next_line_data_o <= nxt_pair;
            end
        end
    end

endmodule

// File: tb/tb_resize_line_store.sv
// Self-checking bench for resize_line_store: table-driven reads through a
// scoreboard plus hand-written sequences for backpressure, bottom edge,
// simultaneous write/release and reset mid-line.
module tb_resize_line_store;
    import resize_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [11:0]          img_width;
    logic [10:0]          img_height;
    logic                 valid_i;
    logic [PIX_W-1:0]     data_i;
    logic                 wr_ready;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_finish;
    logic                 rd_ready;
    logic                 valid_o;
    logic [2*PIX_W-1:0]   cur_line_data_o;
    logic [2*PIX_W-1:0]   next_line_data_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [47:0] cur;
        logic [47:0] nxt;
        int          due;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          addr;
        logic [47:0] cur;
        logic [47:0] nxt;
    } vec_t;
    vec_t tab[8];

    resize_line_store dut (
        .clk              (clk),
        .reset            (reset),
        .img_width        (img_width),
        .img_height       (img_height),
        .valid_i          (valid_i),
        .data_i           (data_i),
        .wr_ready         (wr_ready),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_finish        (rd_finish),
        .rd_ready         (rd_ready),
        .valid_o          (valid_o),
        .cur_line_data_o  (cur_line_data_o),
        .next_line_data_o (next_line_data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int f, input int l, input int c);
        return 24'(f * 65536 + l * 256 + c);
    endfunction

    // Reference pair: clamp the address, replicate the right edge.
    function automatic logic [47:0] exp_pair(input int f, input int l, input int a, input int w);
        int c0;
        int c1;
        c0 = (a > w - 1) ? w - 1 : a;
        c1 = (c0 + 1 > w - 1) ? w - 1 : c0 + 1;
        return {pix(f, l, c0), pix(f, l, c1)};
    endfunction

    // Scoreboard consumer: every valid_o beat must match the oldest request
    // and arrive exactly two cycles after it was issued.
    always @(negedge clk) begin
        sb_t e;
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected valid_o", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("read latency", 64'(cyc), 64'(e.due));
                check("cur_line_data", 64'(cur_line_data_o), 64'(e.cur));
                check("next_line_data", 64'(next_line_data_o), 64'(e.nxt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_px(input int f, input int l, input int c);
        @(negedge clk);
        valid_i   = 1'b1;
        data_i    = pix(f, l, c);
        rd_en     = 1'b0;
        rd_finish = 1'b0;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        valid_i   = 1'b0;
        rd_en     = 1'b0;
        rd_finish = 1'b0;
    endtask

    task automatic drive_finish();
        @(negedge clk);
        valid_i   = 1'b0;
        rd_en     = 1'b0;
        rd_finish = 1'b1;
    endtask

    task automatic drive_read(input int a, input logic [47:0] ec, input logic [47:0] en);
        sb_t e;
        @(negedge clk);
        valid_i   = 1'b0;
        rd_finish = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = ADDR_W'(a);
        e.cur = ec;
        e.nxt = en;
        e.due = cyc + 2;
        sb_q.push_back(e);
    endtask

    task automatic write_line(input int f, input int l, input int w);
        for (int c = 0; c < w; c++) drive_px(f, l, c);
        drive_idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        sb_t e;

        tab[0] = '{3,    48'h000003_000004, 48'h000103_000104};
        tab[1] = '{7,    48'h000007_000007, 48'h000107_000107};
        tab[2] = '{4,    48'h000004_000005, 48'h000104_000105};
        tab[3] = '{0,    48'h000000_000001, 48'h000100_000101};
        tab[4] = '{9,    48'h000007_000007, 48'h000107_000107};
        tab[5] = '{1,    48'h000001_000002, 48'h000101_000102};
        tab[6] = '{6,    48'h000006_000007, 48'h000106_000107};
        tab[7] = '{2047, 48'h000007_000007, 48'h000107_000107};

        reset      = 1'b1;
        valid_i    = 1'b0;
        data_i     = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_finish  = 1'b0;
        img_width  = 12'd8;
        img_height = 11'd4;

        // Reset state.
        @(negedge clk);
        check("wr_ready in reset", 64'(wr_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("rd_ready after reset", 64'(rd_ready), 64'd0);
        check("valid_o after reset", 64'(valid_o), 64'd0);
        check("cur data after reset", 64'(cur_line_data_o), 64'd0);
        check("next data after reset", 64'(next_line_data_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("wr_ready out of reset", 64'(wr_ready), 64'd1);

        // Lines 0 and 1; rd_ready rises one cycle after the 16th accept.
        write_line(0, 0, 8);
        for (int c = 0; c < 7; c++) drive_px(0, 1, c);
        @(negedge clk);
        check("rd_ready before 16th accept", 64'(rd_ready), 64'd0);
        valid_i = 1'b1;
        data_i  = pix(0, 1, 7);
        @(negedge clk);
        valid_i = 1'b0;
        check("rd_ready after 16th accept", 64'(rd_ready), 64'd1);

        // Back-to-back table reads: basic, swap, right edge, clamp.
        for (int i = 0; i < 8; i++) drive_read(tab[i].addr, tab[i].cur, tab[i].nxt);
        drive_idle();
        drain();

        // Backpressure: third line fills the ring, extra beats are dropped.
        for (int c = 0; c < 7; c++) drive_px(0, 2, c);
        @(negedge clk);
        check("wr_ready before 24th accept", 64'(wr_ready), 64'd1);
        valid_i = 1'b1;
        data_i  = pix(0, 2, 7);
        @(negedge clk);
        check("wr_ready after 24th accept", 64'(wr_ready), 64'd0);
        data_i = 24'hBADBAD;
        repeat (3) begin
            @(negedge clk);
            check("wr_ready held low", 64'(wr_ready), 64'd0);
        end
        drive_finish();
        drive_idle();
        check("wr_ready after rd_finish", 64'(wr_ready), 64'd1);
        write_line(0, 3, 8);
        check("wr_ready full again", 64'(wr_ready), 64'd0);

        // Current line is now line 1.
        drive_read(2, exp_pair(0, 1, 2, 8), exp_pair(0, 2, 2, 8));
        drive_idle();
        drain();

        // Bottom edge: two more releases leave only line 3.
        drive_finish();
        drive_finish();
        drive_idle();
        check("rd_ready on bottom line", 64'(rd_ready), 64'd1);
        drive_read(0, exp_pair(0, 3, 0, 8), exp_pair(0, 3, 0, 8));
        drive_read(7, exp_pair(0, 3, 7, 8), exp_pair(0, 3, 7, 8));
        drive_read(5, exp_pair(0, 3, 5, 8), exp_pair(0, 3, 5, 8));
        drive_idle();
        drain();

        // Release the last line, then an ignored release on an empty store.
        drive_finish();
        drive_idle();
        check("rd_ready when empty", 64'(rd_ready), 64'd0);
        check("wr_ready when empty", 64'(wr_ready), 64'd1);
        drive_finish();
        drive_idle();
        check("wr_ready after ignored finish", 64'(wr_ready), 64'd1);

        // Simultaneous line completion, release and read.
        write_line(1, 0, 8);
        check("rd_ready with one line", 64'(rd_ready), 64'd0);
        write_line(1, 1, 8);
        check("rd_ready with two lines", 64'(rd_ready), 64'd1);
        for (int c = 0; c < 7; c++) drive_px(1, 2, c);
        @(negedge clk);
        valid_i   = 1'b1;
        data_i    = pix(1, 2, 7);
        rd_finish = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = ADDR_W'(1);
        e.cur = exp_pair(1, 0, 1, 8);
        e.nxt = exp_pair(1, 1, 1, 8);
        e.due = cyc + 2;
        sb_q.push_back(e);
        drive_idle();
        check("rd_ready after simultaneous", 64'(rd_ready), 64'd1);
        check("wr_ready after simultaneous", 64'(wr_ready), 64'd1);
        drive_read(5, exp_pair(1, 1, 5, 8), exp_pair(1, 2, 5, 8));
        drive_read(7, exp_pair(1, 1, 7, 8), exp_pair(1, 2, 7, 8));
        drive_idle();
        drain();

        // Reset in the middle of a line.
        for (int c = 0; c < 5; c++) drive_px(1, 3, c);
        @(negedge clk);
        valid_i = 1'b0;
        reset   = 1'b1;
        #1;
        check("wr_ready during reset", 64'(wr_ready), 64'd0);
        check("rd_ready during reset", 64'(rd_ready), 64'd0);
        @(negedge clk);
        check("valid_o after mid reset", 64'(valid_o), 64'd0);
        check("cur data after mid reset", 64'(cur_line_data_o), 64'd0);
        check("next data after mid reset", 64'(next_line_data_o), 64'd0);
        check("rd_ready after mid reset", 64'(rd_ready), 64'd0);
        reset      = 1'b0;
        img_width  = 12'd6;
        img_height = 11'd2;

        // New frame with a different geometry.
        write_line(2, 0, 6);
        write_line(2, 1, 6);
        check("rd_ready new frame", 64'(rd_ready), 64'd1);
        drive_read(0, exp_pair(2, 0, 0, 6), exp_pair(2, 1, 0, 6));
        drive_read(3, exp_pair(2, 0, 3, 6), exp_pair(2, 1, 3, 6));
        drive_read(5, exp_pair(2, 0, 5, 6), exp_pair(2, 1, 5, 6));
        drive_idle();
        drain();
        drive_finish();
        drive_idle();
        check("rd_ready new frame bottom", 64'(rd_ready), 64'd1);
        drive_read(2, exp_pair(2, 1, 2, 6), exp_pair(2, 1, 2, 6));
        drive_idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
